// File: rtl/mult_sequencer.sv
// mult_sequencer: collects two signed decimal operands from keys, launches one multiply and selects the display value
module mult_sequencer #(
    parameter int N       = 8,
    parameter int DIGITS  = 3,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           key_valid,
    input  logic [3:0]     key_code,
    input  logic           mult_ready,
    input  logic [2*N-1:0] mult_result,
    output logic [N-1:0]   num_1,
    output logic [N-1:0]   num_2,
    output logic           mult_valid,
    output logic [2*N-1:0] disp_value,
    output logic [1:0]     disp_sel,
    output logic           busy,
    output logic           entry_err
);
    localparam int DW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [N+3:0] MAX_POS = (N+4)'(2**(N-1) - 1);
    localparam logic [N-1:0] MAG_MIN_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {ENTER_A, ENTER_B, START, WAIT_MULT, SHOW} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   mag_q, mag_d;
    logic           neg_q, neg_d;
    logic [DW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [N-1:0]   num_1_q, num_1_d, num_2_q, num_2_d;
    logic [2*N-1:0] result_q, result_d;
    logic           mult_valid_q, mult_valid_d, busy_q, busy_d, entry_err_q, entry_err_d;
    logic [2*N-1:0] disp_value_q, disp_value_d;
    logic [1:0]     disp_sel_q, disp_sel_d;
    logic [N+3:0]   new_mag, limit;
    logic [N-1:0]   entry_val;
    logic [2*N-1:0] live_ext;
    logic           is_digit, is_sign, is_enter, is_clear;

    assign is_digit = key_valid && key_code <= 4'd9;
    assign is_sign  = key_valid && key_code == 4'hA;
    assign is_enter = key_valid && key_code == 4'hB;
    assign is_clear = key_valid && key_code == 4'hC;

    // Key handling, multiplier handshake and timeout sequencing
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        tmo_d       = '0;
        num_1_d     = num_1_q;
        num_2_d     = num_2_q;
        result_d    = result_q;
        entry_err_d = 1'b0;
        new_mag     = (N+4)'(mag_q) * (N+4)'(10) + (N+4)'(key_code);
        limit       = MAX_POS + (N+4)'(neg_q);
        entry_val   = neg_q ? -mag_q : mag_q;
        case (state_q)
            ENTER_A, ENTER_B: begin
                if (is_digit) begin
                    if (cnt_q < DW'(DIGITS) && new_mag <= limit) begin
                        mag_d = new_mag[N-1:0];
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        entry_err_d = 1'b1;
                    end
                end else if (is_sign) begin
                    if (!(neg_q && mag_q == MAG_MIN_NEG)) neg_d = !neg_q;
                end else if (is_enter) begin
                    if (state_q == ENTER_A) num_1_d = entry_val;
                    else num_2_d = entry_val;
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = state_q == ENTER_A ? ENTER_B : START;
                end else if (is_clear) begin
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    cnt_d   = '0;
                    num_1_d = '0;
                    state_d = ENTER_A;
                end
            end
            START: state_d = WAIT_MULT;
            WAIT_MULT: begin
                if (mult_ready) begin
                    result_d = mult_result;
                    state_d  = SHOW;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    entry_err_d = 1'b1;
                    state_d     = ENTER_A;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            SHOW: begin
                if (is_digit) begin
                    mag_d   = N'(key_code);
                    neg_d   = 1'b0;
                    cnt_d   = DW'(1);
                    state_d = ENTER_A;
                end else if (is_clear) begin
                    state_d = ENTER_A;
                end
            end
            default: state_d = ENTER_A;
        endcase
    end

    // Registered outputs derived from the next state so a key shows up one cycle later
    always_comb begin
        live_ext     = {{N{1'b0}}, mag_d};
        mult_valid_d = state_d == START;
        busy_d       = state_d == START || state_d == WAIT_MULT;
        disp_sel_d   = state_d == ENTER_A ? 2'd0 : state_d == SHOW ? 2'd2 : 2'd1;
        disp_value_d = (state_d == ENTER_A || state_d == ENTER_B) ? (neg_d ? -live_ext : live_ext) :
                       state_d == SHOW ? result_d : {{N{num_2_d[N-1]}}, num_2_d};
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ENTER_A;
            mag_q        <= '0;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            num_1_q      <= '0;
            num_2_q      <= '0;
            result_q     <= '0;
            mult_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            entry_err_q  <= 1'b0;
            disp_value_q <= '0;
            disp_sel_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            mag_q        <= mag_d;
            neg_q        <= neg_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            num_1_q      <= num_1_d;
            num_2_q      <= num_2_d;
            result_q     <= result_d;
            mult_valid_q <= mult_valid_d;
            busy_q       <= busy_d;
            entry_err_q  <= entry_err_d;
            disp_value_q <= disp_value_d;
            disp_sel_q   <= disp_sel_d;
        end
    end

    assign num_1      = num_1_q;
    assign num_2      = num_2_q;
    assign mult_valid = mult_valid_q;
    assign busy       = busy_q;
    assign entry_err  = entry_err_q;
    assign disp_value = disp_value_q;
    assign disp_sel   = disp_sel_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed key sequences checked against an integer-level model every cycle
module tb_mult_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        mult_ready = 1'b0;
    logic [15:0] mult_result = 16'd0;
    logic [7:0]  num_1, num_2;
    logic        mult_valid, busy, entry_err;
    logic [15:0] disp_value;
    logic [1:0]  disp_sel;

    int tests = 0;
    int fails = 0;
    int mv_count = 0;

    mult_sequencer dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .mult_ready(mult_ready), .mult_result(mult_result), .num_1(num_1), .num_2(num_2),
        .mult_valid(mult_valid), .disp_value(disp_value), .disp_sel(disp_sel),
        .busy(busy), .entry_err(entry_err)
    );

    always #5 clk = ~clk;

    // Model: 0 entering A, 1 entering B, 2 start, 3 waiting, 4 showing result
    int m_phase = 0, m_mag = 0, m_cnt = 0, m_a = 0, m_b = 0, m_res = 0, m_wait = 0;
    bit m_neg = 0, m_err = 0, started = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(posedge clk) begin
        started = 1;
        m_err = 0;
        if (reset) begin
            m_phase = 0; m_mag = 0; m_neg = 0; m_cnt = 0; m_a = 0; m_b = 0; m_res = 0; m_wait = 0;
        end else if (m_phase <= 1) begin
            if (key_valid && key_code <= 9) begin
                if (m_cnt < 3 && m_mag * 10 + int'(key_code) <= (m_neg ? 128 : 127)) begin
                    m_mag = m_mag * 10 + int'(key_code);
                    m_cnt++;
                end else m_err = 1;
            end else if (key_valid && key_code == 4'hA) begin
                if (!(m_neg && m_mag == 128)) m_neg = !m_neg;
            end else if (key_valid && key_code == 4'hB) begin
                if (m_phase == 0) m_a = m_neg ? -m_mag : m_mag;
                else m_b = m_neg ? -m_mag : m_mag;
                m_mag = 0; m_neg = 0; m_cnt = 0;
                m_phase++;
            end else if (key_valid && key_code == 4'hC) begin
                m_mag = 0; m_neg = 0; m_cnt = 0; m_a = 0; m_phase = 0;
            end
        end else if (m_phase == 2) begin
            m_phase = 3; m_wait = 0;
        end else if (m_phase == 3) begin
            if (mult_ready) begin
                m_res = int'($signed(mult_result)); m_phase = 4;
            end else if (m_wait == 63) begin
                m_err = 1; m_phase = 0;
            end else m_wait++;
        end else begin
            if (key_valid && key_code <= 9) begin
                m_mag = int'(key_code); m_neg = 0; m_cnt = 1; m_phase = 0;
            end else if (key_valid && key_code == 4'hC) m_phase = 0;
        end
    end

    // Single compare process against the model on every cycle
    always @(negedge clk) begin
        if (started) begin
            chk("num_1", int'($signed(num_1)), m_a);
            chk("num_2", int'($signed(num_2)), m_b);
            chk("mult_valid", int'(mult_valid), int'(m_phase == 2));
            chk("busy", int'(busy), int'(m_phase == 2 || m_phase == 3));
            chk("entry_err", int'(entry_err), int'(m_err));
            chk("disp_sel", int'(disp_sel), m_phase == 0 ? 0 : m_phase == 4 ? 2 : 1);
            chk("disp_value", int'($signed(disp_value)),
                m_phase <= 1 ? (m_neg ? -m_mag : m_mag) : m_phase == 4 ? m_res : m_b);
            if (mult_valid) mv_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] k, output logic err);
        key_valid = 1'b1;
        key_code = k;
        tick();
        err = entry_err;
        key_valid = 1'b0;
        tick();
    endtask

    task automatic ready_pulse(input logic [15:0] r);
        mult_ready = 1'b1;
        mult_result = r;
        tick();
        mult_ready = 1'b0;
    endtask

    initial begin
        logic e;
        int n, mv0;
        tick();
        tick();
        chk("rst_disp_sel", int'(disp_sel), 0);
        chk("rst_disp_value", int'(disp_value), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick();
        // 1: 12 * -5
        mv0 = mv_count;
        key(4'd1, e); key(4'd2, e); key(4'hB, e);
        chk("t1_num_1", int'(num_1), 12);
        key(4'hA, e); key(4'd5, e);
        chk("t1_disp_neg5", int'(disp_value), 32'hFFFB);
        key(4'hB, e);
        chk("t1_num_2", int'(num_2), 32'hFB);
        chk("t1_mv_pulses", mv_count - mv0, 1);
        repeat (18) tick();
        ready_pulse(16'hFFC4);
        chk("t1_sel", int'(disp_sel), 2);
        chk("t1_disp", int'(disp_value), 32'hFFC4);
        // 2: -128 accepted, +128 rejected, sign ignored at -128
        key(4'hC, e);
        key(4'hA, e); key(4'd1, e); key(4'd2, e); key(4'd8, e);
        chk("t2_err_neg128", int'(e), 0);
        key(4'hA, e);
        chk("t2_sign_ignored", int'(disp_value), 32'hFF80);
        key(4'hB, e);
        chk("t2_num_1", int'(num_1), 32'h80);
        key(4'd1, e); key(4'd2, e); key(4'd8, e);
        chk("t2_err_pos128", int'(e), 1);
        chk("t2_disp12", int'(disp_value), 12);
        key(4'hC, e);
        // 3: digit limit and ignored codes
        key(4'd1, e); key(4'd2, e); key(4'd3, e); key(4'd4, e);
        chk("t3_err_4th", int'(e), 1);
        chk("t3_disp123", int'(disp_value), 123);
        key(4'hD, e);
        chk("t3_ignored_err", int'(e), 0);
        chk("t3_ignored_disp", int'(disp_value), 123);
        key(4'hC, e);
        // 4: empty operands then timeout
        mv0 = mv_count;
        key(4'hB, e); key(4'hB, e);
        chk("t4_num_1", int'(num_1), 0);
        chk("t4_mv_pulses", mv_count - mv0, 1);
        n = 0;
        while (!entry_err && n < 100) begin
            tick();
            n++;
        end
        chk("t4_timeout_cycles", n, 64);
        chk("t4_sel_after_timeout", int'(disp_sel), 0);
        // 5: keys ignored while waiting, then result, then digit restarts A
        key(4'd3, e); key(4'hB, e); key(4'd4, e); key(4'hB, e);
        key(4'hC, e); key(4'd9, e);
        chk("t5_wait_err", int'(e), 0);
        key(4'hA, e);
        chk("t5_busy", int'(busy), 1);
        chk("t5_disp_b", int'(disp_value), 4);
        ready_pulse(16'd12);
        chk("t5_sel_show", int'(disp_sel), 2);
        chk("t5_disp_show", int'(disp_value), 12);
        key(4'd7, e);
        chk("t5_sel_a", int'(disp_sel), 0);
        chk("t5_disp7", int'(disp_value), 7);
        // 6: reset while ready arrives in WAIT_MULT
        key(4'hC, e);
        key(4'd1, e); key(4'hB, e); key(4'd2, e); key(4'hB, e);
        tick();
        reset = 1'b1;
        mult_ready = 1'b1;
        mult_result = 16'h1234;
        tick();
        reset = 1'b0;
        mult_ready = 1'b0;
        chk("t6_disp", int'(disp_value), 0);
        chk("t6_sel", int'(disp_sel), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_num_1", int'(num_1), 0);
        chk("t6_num_2", int'(num_2), 0);
        key(4'd5, e);
        chk("t6_disp5", int'(disp_value), 5);
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
